// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch controller states: issuing a request, or parked on a skid-buffered word.
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_e;

    // Which redirect source wins this cycle.
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_WB     = 2'd2
    } redir_sel_e;

    // Instruction word used as a pipeline bubble.
    localparam logic [23:0] NOP = 24'h000000;

    // A write to $pc from Writeback is older in program order than a branch
    // in Execute, so it takes priority.
    function automatic redir_sel_e redir_select(input logic pcsrc_w, input logic branch_e);
        if (pcsrc_w) begin
            return RD_WB;
        end
        if (branch_e) begin
            return RD_BRANCH;
        end
        return RD_NONE;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/ready bus between fetch (master) and imem (slave).
interface fetch_if #(
    parameter int unsigned N = 24
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_rdata;
    logic         imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/fetch_register_FD.sv
// F/D pipeline register: flush beats stall, stall beats load.
module register_FD #(
    parameter int unsigned  N   = 24,
    parameter logic [N-1:0] NOP = N'(fetch_pkg::NOP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] InstrF_i,
    input  logic [N-1:0] PCF_i,
    input  logic [N-1:0] PCPlus8F_i,
    input  logic         ValidF_i,
    output logic [N-1:0] InstrD_o,
    output logic [N-1:0] PCD_o,
    output logic [N-1:0] PCPlus8D_o,
    output logic         ValidD_o
);
    import fetch_pkg::*;

    // Pipeline register with asynchronous reset to a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD_o   <= NOP;
            PCD_o      <= '0;
            PCPlus8D_o <= '0;
            ValidD_o   <= 1'b0;
        end else if (clr) begin
            InstrD_o   <= NOP;
            PCD_o      <= '0;
            PCPlus8D_o <= '0;
            ValidD_o   <= 1'b0;
        end else if (en) begin
            InstrD_o   <= InstrF_i;
            PCD_o      <= PCF_i;
            PCPlus8D_o <= PCPlus8F_i;
            ValidD_o   <= ValidF_i;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, imem handshake, skid buffer, redirects, F/D register.
module fetch #(
    parameter int unsigned  N        = 24,
    parameter int unsigned  PC_STEP  = 4,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] NOP      = N'(fetch_pkg::NOP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         BranchTakenE,
    input  logic [N-1:0] ALUResultE,
    input  logic         PCSrcW,
    input  logic [N-1:0] ResultW,
    fetch_if.master      imem,
    output logic [N-1:0] InstrD,
    output logic [N-1:0] PCD,
    output logic [N-1:0] PCPlus8D,
    output logic         ValidD,
    output logic         FetchBusy
);
    import fetch_pkg::*;

    localparam logic [N-1:0] STEP  = N'(PC_STEP);
    localparam logic [N-1:0] STEP2 = N'(2 * PC_STEP);

    fetch_state_e state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] buf_instr_q, buf_instr_d;
    logic [N-1:0] buf_pc_q, buf_pc_d;
    logic         pend_q, pend_d;
    logic [N-1:0] pend_tgt_q, pend_tgt_d;

    redir_sel_e   redir_sel;
    logic         redir;
    logic [N-1:0] redir_tgt;

    logic [N-1:0] fd_instr;
    logic [N-1:0] fd_pc;
    logic [N-1:0] fd_pc8;
    logic         fd_valid;

    // Redirect source selection and target mux.
    always_comb begin
        redir_sel = redir_select(PCSrcW, BranchTakenE);
        redir_tgt = '0;
        unique case (redir_sel)
            RD_WB:     redir_tgt = ResultW;
            RD_BRANCH: redir_tgt = ALUResultE;
            default:   redir_tgt = '0;
        endcase
        redir = (redir_sel != RD_NONE);
    end

    // Request outputs; reset kills the request combinationally.
    always_comb begin
        imem.imem_req  = (state_q == S_FETCH) && !rst;
        imem.imem_addr = pc_q;
        FetchBusy      = imem.imem_req && !imem.imem_ready;
    end

    // Next-state, PC, skid buffer, pending redirect and F/D input selection.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        fd_instr    = NOP;
        fd_pc       = '0;
        fd_valid    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (!imem.imem_ready) begin
                    // Request must complete first; remember the newest redirect.
                    if (redir) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = redir_tgt;
                    end
                end else if (redir) begin
                    pc_d   = redir_tgt;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pc_d   = pend_tgt_q;
                    pend_d = 1'b0;
                end else if (StallF) begin
                    buf_instr_d = imem.imem_rdata;
                    buf_pc_d    = pc_q;
                    state_d     = S_HOLD;
                end else begin
                    fd_instr = imem.imem_rdata;
                    fd_pc    = pc_q;
                    fd_valid = 1'b1;
                    pc_d     = pc_q + STEP;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = redir_tgt;
                    state_d = S_FETCH;
                end else if (!StallF) begin
                    fd_instr = buf_instr_q;
                    fd_pc    = buf_pc_q;
                    fd_valid = 1'b1;
                    pc_d     = buf_pc_q + STEP;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        fd_pc8 = fd_valid ? (fd_pc + STEP2) : '0;
    end

    // Fetch state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

    register_FD #(
        .N   (N),
        .NOP (NOP)
    ) u_register_FD (
        .clk        (clk),
        .rst        (rst),
        .en         (!StallD),
        .clr        (FlushD),
        .InstrF_i   (fd_instr),
        .PCF_i      (fd_pc),
        .PCPlus8F_i (fd_pc8),
        .ValidF_i   (fd_valid),
        .InstrD_o   (InstrD),
        .PCD_o      (PCD),
        .PCPlus8D_o (PCPlus8D),
        .ValidD_o   (ValidD)
    );

endmodule

// File: tb/tb_fetch.sv
// Testbench for the fetch stage.
module tb_fetch;

    typedef struct packed {
        logic [23:0] instr;
        logic [23:0] pc;
        logic [23:0] pc8;
        logic        valid;
    } fd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        BranchTakenE = 1'b0, PCSrcW = 1'b0;
    logic [23:0] ALUResultE = '0, ResultW = '0;
    logic        ready = 1'b1;
    logic [23:0] InstrD, PCD, PCPlus8D;
    logic        ValidD, FetchBusy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    fd_t         sb[$];

    fetch_if #(.N(24)) imem_bus();

    function automatic logic [23:0] memword(input logic [23:0] a);
        return a ^ 24'h5A5A5A;
    endfunction

    function automatic fd_t W(input logic [23:0] a);
        fd_t f;
        f.instr = memword(a);
        f.pc    = a;
        f.pc8   = a + 24'd8;
        f.valid = 1'b1;
        return f;
    endfunction

    function automatic fd_t BUB();
        fd_t f;
        f = '0;
        return f;
    endfunction

    assign imem_bus.imem_rdata = memword(imem_bus.imem_addr);
    assign imem_bus.imem_ready = ready;

    always #5 clk = ~clk;

    fetch #(
        .N        (24),
        .PC_STEP  (4),
        .RESET_PC (24'h000000),
        .NOP      (24'h000000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .imem         (imem_bus.master),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD),
        .FetchBusy    (FetchBusy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check request outputs mid-cycle, then
    // check the F/D register after the edge against the scoreboard.
    task automatic step(input string tag,
                        input logic rdy, input logic sf, input logic sd, input logic fl,
                        input logic br, input logic [23:0] alu,
                        input logic pcs, input logic [23:0] res,
                        input logic exp_req, input logic [23:0] exp_addr, input logic exp_busy,
                        input fd_t exp_fd);
        fd_t e;
        ready = rdy; StallF = sf; StallD = sd; FlushD = fl;
        BranchTakenE = br; ALUResultE = alu; PCSrcW = pcs; ResultW = res;
        sb.push_back(exp_fd);
        @(negedge clk);
        check({tag, ".req"}, {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
        if (exp_req) check({tag, ".addr"}, {8'd0, imem_bus.imem_addr}, {8'd0, exp_addr});
        check({tag, ".busy"}, {31'd0, FetchBusy}, {31'd0, exp_busy});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".valid"}, {31'd0, ValidD}, {31'd0, e.valid});
        check({tag, ".instr"}, {8'd0, InstrD}, {8'd0, e.instr});
        if (e.valid) begin
            check({tag, ".pcd"}, {8'd0, PCD}, {8'd0, e.pc});
            check({tag, ".pc8"}, {8'd0, PCPlus8D}, {8'd0, e.pc8});
        end
    endtask

    initial begin
        #12;
        check("rst.req",   {31'd0, imem_bus.imem_req}, 32'd0);
        check("rst.instr", {8'd0, InstrD}, 32'd0);
        check("rst.valid", {31'd0, ValidD}, 32'd0);
        check("rst.pcd",   {8'd0, PCD}, 32'd0);
        check("rst.pc8",   {8'd0, PCPlus8D}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait fetch, then two wait states at 0x4.
        step("t1a", 1,0,0,0, 0,'0, 0,'0, 1, 24'h000000, 0, W(24'h000000));
        step("t2a", 0,0,0,0, 0,'0, 0,'0, 1, 24'h000004, 1, BUB());
        step("t2b", 0,0,0,0, 0,'0, 0,'0, 1, 24'h000004, 1, BUB());
        step("t2c", 1,0,0,0, 0,'0, 0,'0, 1, 24'h000004, 0, W(24'h000004));
        // StallF+StallD as the word at 0x8 returns: parked in the skid buffer.
        step("t3a", 1,1,1,0, 0,'0, 0,'0, 1, 24'h000008, 0, W(24'h000004));
        step("t3b", 1,1,1,0, 0,'0, 0,'0, 0, 24'h000008, 0, W(24'h000004));
        step("t3c", 1,0,0,0, 0,'0, 0,'0, 0, 24'h000008, 0, W(24'h000008));
        // Branch during wait states at 0xC; the newer target 0x40 wins.
        step("t4a", 0,0,0,0, 1,24'h000030, 0,'0, 1, 24'h00000C, 1, BUB());
        step("t4b", 0,0,0,0, 1,24'h000040, 0,'0, 1, 24'h00000C, 1, BUB());
        step("t4c", 1,0,0,0, 0,'0, 0,'0, 1, 24'h00000C, 0, BUB());
        step("t4d", 1,0,0,0, 0,'0, 0,'0, 1, 24'h000040, 0, W(24'h000040));
        // Writeback redirect beats branch; flush beats stall.
        step("t5a", 1,0,0,0, 1,24'h000040, 1,24'h000080, 1, 24'h000044, 0, BUB());
        step("t5b", 1,0,1,1, 0,'0, 0,'0, 1, 24'h000080, 0, BUB());
        step("t5c", 1,0,0,0, 0,'0, 0,'0, 1, 24'h000084, 0, W(24'h000084));
        // Redirect while parked in the hold state drops the buffered word.
        step("h1",  1,1,1,0, 0,'0, 0,'0, 1, 24'h000088, 0, W(24'h000084));
        step("h2",  1,1,1,0, 1,24'h000200, 0,'0, 0, 24'h000088, 0, W(24'h000084));
        step("h3",  1,0,0,0, 0,'0, 0,'0, 1, 24'h000200, 0, W(24'h000200));
        // PC wraps at the top of the address space.
        step("w1",  1,0,0,0, 0,'0, 1,24'hFFFFFC, 1, 24'h000204, 0, BUB());
        step("w2",  1,0,0,0, 0,'0, 0,'0, 1, 24'hFFFFFC, 0, W(24'hFFFFFC));
        step("w3",  1,0,0,0, 0,'0, 0,'0, 1, 24'h000000, 0, W(24'h000000));
        // Reset in the middle of a wait state.
        step("r1",  0,0,0,0, 0,'0, 0,'0, 1, 24'h000004, 1, BUB());
        #2 rst = 1'b1;
        #1;
        check("r2.req",   {31'd0, imem_bus.imem_req}, 32'd0);
        check("r2.busy",  {31'd0, FetchBusy}, 32'd0);
        check("r2.instr", {8'd0, InstrD}, 32'd0);
        check("r2.valid", {31'd0, ValidD}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step("r3",  1,0,0,0, 0,'0, 0,'0, 1, 24'h000000, 0, W(24'h000000));
        step("r4",  1,0,0,0, 0,'0, 0,'0, 1, 24'h000004, 0, W(24'h000004));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
